// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: pipeline W-stage, MDU result and register-file write port bundle.
interface wb_port_arbiter_if #(
  parameter int DAT_WIDTH  = 32,
  parameter int REG_AW     = 5,
  parameter int FIFO_DEPTH = 2
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic                 RegWrite_W;
  logic [REG_AW-1:0]    Rd_W;
  logic [DAT_WIDTH-1:0] Result_W;
  logic                 mdu_valid;
  logic [REG_AW-1:0]    mdu_rd;
  logic [DAT_WIDTH-1:0] mdu_data;
  logic                 mdu_ready;
  logic                 rf_we;
  logic [REG_AW-1:0]    rf_waddr;
  logic [DAT_WIDTH-1:0] rf_wdata;
  logic                 wb_stall;
  logic [CW-1:0]        pend_count;
  modport master (
    output RegWrite_W, Rd_W, Result_W, mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready, rf_we, rf_waddr, rf_wdata, wb_stall, pend_count
  );
  modport slave (
    input  RegWrite_W, Rd_W, Result_W, mdu_valid, mdu_rd, mdu_data,
    output mdu_ready, rf_we, rf_waddr, rf_wdata, wb_stall, pend_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the RF write port between the W stage (always wins) and a
// small FIFO of MDU results that drains into idle slots, requesting a stall on starvation.
module wb_port_arbiter #(
  parameter int DAT_WIDTH    = 32,
  parameter int REG_AW       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst_n,
  wb_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;
  localparam int EW = REG_AW + DAT_WIDTH;
  typedef enum logic [1:0] {IDLE, PEND, STALL} state_t;
  state_t        state_q, state_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] pend_q, pend_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          pipe_wr, has, push, pop, blocked, drained;
  always_comb begin
    pipe_wr = rst_n && bus.RegWrite_W && bus.Rd_W != '0;
    has = pend_q != '0;
    pop = !pipe_wr && has;
    blocked = pipe_wr && has;
    bus.mdu_ready = rst_n && pend_q != CW'(FIFO_DEPTH);
    push = bus.mdu_valid && bus.mdu_ready && bus.mdu_rd != '0;
    bus.rf_we = pipe_wr || has;
    {bus.rf_waddr, bus.rf_wdata} = pipe_wr ? {bus.Rd_W, bus.Result_W} : has ? mem_q[rd_ptr_q] : '0;
    bus.wb_stall = state_q == STALL;
    bus.pend_count = pend_q;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {bus.mdu_rd, bus.mdu_data};
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    pend_d = pend_q + CW'(push) - CW'(pop);
    drained = pop && !push && pend_q == CW'(1);
    // A push racing the last pop keeps the FSM where it is.
    state_d = drained ? IDLE :
              (state_q == IDLE && push) ? PEND :
              (state_q == PEND && blocked && starve_q == SW'(STARVE_LIMIT - 1)) ? STALL :
              (state_q == IDLE || state_q == PEND || state_q == STALL) ? state_q : IDLE;
    starve_d = (pop || state_d == IDLE) ? '0 :
               (blocked && starve_q != '1) ? starve_q + SW'(1) : starve_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pend_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pend_q   <= pend_d;
      starve_q <= starve_d;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vector table, reset-mid-drain sequence and randomized
// traffic checked against a queue-based model of the arbiter.
module tb_wb_port_arbiter;
  localparam int DW = 32, RW = 5, FD = 2, SL = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  wb_port_arbiter_if #(.DAT_WIDTH(DW), .REG_AW(RW), .FIFO_DEPTH(FD)) bus();
  wb_port_arbiter #(.DAT_WIDTH(DW), .REG_AW(RW), .FIFO_DEPTH(FD), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  typedef struct {
    logic rw; logic [RW-1:0] rd; logic [DW-1:0] res;
    logic mv; logic [RW-1:0] mrd; logic [DW-1:0] md;
    logic we; logic [RW-1:0] wa; logic [DW-1:0] wd;
    logic rdy; logic st; logic [1:0] pc;
  } vec_t;
  vec_t tbl [26];
  int tests = 0;
  int fails = 0;
  logic [RW+DW-1:0] q [$];
  bit stall_m = 0;
  int blk = 0;
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic drive(logic rw, logic [RW-1:0] rd, logic [DW-1:0] res,
                       logic mv, logic [RW-1:0] mrd, logic [DW-1:0] md);
    bus.RegWrite_W = rw; bus.Rd_W = rd; bus.Result_W = res;
    bus.mdu_valid = mv; bus.mdu_rd = mrd; bus.mdu_data = md;
  endtask
  task automatic check_model(string tag);
    logic pw;
    logic [RW+DW-1:0] port;
    pw = bus.RegWrite_W && bus.Rd_W != 0;
    port = pw ? {bus.Rd_W, bus.Result_W} : (q.size() > 0) ? q[0] : '0;
    chk({tag, " rf_we"}, bus.rf_we, pw || q.size() > 0);
    chk({tag, " rf_waddr"}, bus.rf_waddr, port[RW+DW-1:DW]);
    chk({tag, " rf_wdata"}, bus.rf_wdata, port[DW-1:0]);
    chk({tag, " mdu_ready"}, bus.mdu_ready, q.size() < FD);
    chk({tag, " wb_stall"}, bus.wb_stall, stall_m);
    chk({tag, " pend_count"}, bus.pend_count, q.size());
  endtask
  task automatic advance();
    logic pw, blocked, popped, acc;
    int n;
    @(posedge clk);
    n = q.size();
    pw = bus.RegWrite_W && bus.Rd_W != 0;
    blocked = pw && n > 0;
    popped = !pw && n > 0;
    acc = bus.mdu_valid && n < FD;
    if (popped) void'(q.pop_front());
    if (acc && bus.mdu_rd != 0) q.push_back({bus.mdu_rd, bus.mdu_data});
    if (popped) blk = 0;
    else if (blocked) blk++;
    stall_m = stall_m ? q.size() != 0 : (blocked && blk >= SL);
    #1;
  endtask
  initial begin
    tbl[0]  = '{0,0,0, 1,5,32'hDEADBEEF, 0,0,0, 1,0,0};
    tbl[1]  = '{0,0,0, 0,0,0, 1,5,32'hDEADBEEF, 1,0,1};
    tbl[2]  = '{1,3,32'h33, 1,7,32'h77, 1,3,32'h33, 1,0,0};
    tbl[3]  = '{1,3,32'h44, 0,0,0, 1,3,32'h44, 1,0,1};
    tbl[4]  = '{0,0,0, 0,0,0, 1,7,32'h77, 1,0,1};
    tbl[5]  = '{0,0,0, 1,0,32'h99, 0,0,0, 1,0,0};
    tbl[6]  = '{0,0,0, 0,0,0, 0,0,0, 1,0,0};
    tbl[7]  = '{0,0,0, 1,9,32'h11, 0,0,0, 1,0,0};
    tbl[8]  = '{1,0,32'h55, 0,0,0, 1,9,32'h11, 1,0,1};
    tbl[9]  = '{0,0,0, 0,0,0, 0,0,0, 1,0,0};
    tbl[10] = '{1,4,32'h1, 1,6,32'h66, 1,4,32'h1, 1,0,0};
    tbl[11] = '{1,4,32'h2, 0,0,0, 1,4,32'h2, 1,0,1};
    tbl[12] = '{1,4,32'h3, 0,0,0, 1,4,32'h3, 1,0,1};
    tbl[13] = '{1,4,32'h4, 0,0,0, 1,4,32'h4, 1,0,1};
    tbl[14] = '{1,4,32'h5, 0,0,0, 1,4,32'h5, 1,0,1};
    tbl[15] = '{1,4,32'h6, 0,0,0, 1,4,32'h6, 1,1,1};
    tbl[16] = '{0,0,0, 0,0,0, 1,6,32'h66, 1,1,1};
    tbl[17] = '{0,0,0, 0,0,0, 0,0,0, 1,0,0};
    tbl[18] = '{1,8,32'h80, 1,1,32'hA1, 1,8,32'h80, 1,0,0};
    tbl[19] = '{1,8,32'h81, 1,2,32'hA2, 1,8,32'h81, 1,0,1};
    tbl[20] = '{1,8,32'h82, 1,3,32'hA3, 1,8,32'h82, 0,0,2};
    tbl[21] = '{0,0,0, 1,3,32'hA3, 1,1,32'hA1, 0,0,2};
    tbl[22] = '{1,8,32'h83, 1,3,32'hA3, 1,8,32'h83, 1,0,1};
    tbl[23] = '{0,0,0, 0,0,0, 1,2,32'hA2, 0,0,2};
    tbl[24] = '{0,0,0, 0,0,0, 1,3,32'hA3, 1,0,1};
    tbl[25] = '{0,0,0, 0,0,0, 0,0,0, 1,0,0};
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset rf_we", bus.rf_we, 0);
    chk("reset mdu_ready", bus.mdu_ready, 0);
    chk("reset wb_stall", bus.wb_stall, 0);
    chk("reset pend_count", bus.pend_count, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].rw, tbl[i].rd, tbl[i].res, tbl[i].mv, tbl[i].mrd, tbl[i].md);
      @(negedge clk);
      chk($sformatf("vec%0d rf_we", i), bus.rf_we, tbl[i].we);
      chk($sformatf("vec%0d rf_waddr", i), bus.rf_waddr, tbl[i].wa);
      chk($sformatf("vec%0d rf_wdata", i), bus.rf_wdata, tbl[i].wd);
      chk($sformatf("vec%0d mdu_ready", i), bus.mdu_ready, tbl[i].rdy);
      chk($sformatf("vec%0d wb_stall", i), bus.wb_stall, tbl[i].st);
      chk($sformatf("vec%0d pend_count", i), bus.pend_count, tbl[i].pc);
      advance();
    end
    drive(1, 4, 32'h5, 1, 10, 32'hAAA);
    advance();
    drive(1, 4, 32'h6, 1, 11, 32'hBBB);
    advance();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("predrain pend_count", bus.pend_count, 2);
    rst_n = 1'b0;
    #1;
    chk("rstmid pend_count", bus.pend_count, 0);
    chk("rstmid rf_we", bus.rf_we, 0);
    chk("rstmid wb_stall", bus.wb_stall, 0);
    chk("rstmid mdu_ready", bus.mdu_ready, 0);
    q.delete();
    blk = 0;
    stall_m = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("postrst mdu_ready", bus.mdu_ready, 1);
    chk("postrst pend_count", bus.pend_count, 0);
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 9) < ((i < 1500) ? 7 : 4)), 5'($urandom_range(0, 3)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      @(negedge clk);
      check_model($sformatf("rand%0d", i));
      advance();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
